// File: rtl/loader_write_fifo_if.sv
// ============================================================================
// Module   : loader_write_fifo_if
// Brief    : Loader byte stream handshake plus SDRAM port-A write bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface loader_write_fifo_if;
  logic        in_valid;
  logic [21:0] in_addr;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [21:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_write;

  // master = loader/SDRAM side, slave = the FIFO
  modport master (
    output in_valid, in_addr, in_data,
    input  in_ready,
    input  mem_addr, mem_data, mem_write
  );

  modport slave (
    input  in_valid, in_addr, in_data,
    output in_ready,
    output mem_addr, mem_data, mem_write
  );
endinterface

`default_nettype wire

// File: rtl/loader_write_fifo.sv
// ============================================================================
// Module   : loader_write_fifo
// Brief    : Buffers game-loader bytes and drains one per nes_ce write slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module loader_write_fifo #(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [1:0] SLOT       = 2'd3
) (
  input  wire                  clk,
  input  wire                  reset,
  loader_write_fifo_if.slave   bus,
  input  wire [1:0]            nes_ce,
  input  wire                  load_done_in,
  output logic [DEPTH_LOG2:0]  level,
  output logic                 overflow,
  output logic                 done
);

  localparam int                    c_DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   c_FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   c_LVL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [29:0]           r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_overflow;
  logic                  r_done;
  logic [21:0]           r_mem_addr;
  logic [7:0]            r_mem_data;
  logic                  r_mem_write;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_slot;
  logic w_pop;

  // Pop eligibility looks only at the level held at the start of the cycle,
  // so a byte pushed on a slot edge waits for the next slot.
  assign w_full  = (r_level == c_FULL);
  assign w_empty = (r_level == '0);
  assign w_push  = bus.in_valid & ~w_full;
  assign w_slot  = (nes_ce == SLOT);
  assign w_pop   = w_slot & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.in_addr, bus.in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_write <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (bus.in_valid && w_full) begin
        r_overflow <= 1'b1;
      end

      // mem_* only move on slot edges so each write spans a full nes_ce period
      if (w_slot) begin
        if (w_pop) begin
          {r_mem_addr, r_mem_data} <= r_mem[r_rd_ptr];
          r_mem_write              <= 1'b1;
          r_rd_ptr                 <= r_rd_ptr + c_PTR_ONE;
        end else begin
          r_mem_write <= 1'b0;
        end
      end

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_ONE;
        2'b01:   r_level <= r_level - c_LVL_ONE;
        default: r_level <= r_level;
      endcase

      r_done <= load_done_in & w_empty & ~r_mem_write & ~bus.in_valid;
    end
  end

  assign bus.in_ready  = ~w_full;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_data  = r_mem_data;
  assign bus.mem_write = r_mem_write;
  assign level         = r_level;
  assign overflow      = r_overflow;
  assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_loader_write_fifo.sv
// ============================================================================
// Module   : tb_loader_write_fifo
// Brief    : Directed self-checking bench for loader_write_fifo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_loader_write_fifo;

  logic       clk;
  logic       reset;
  logic [1:0] nes_ce;
  logic       load_done_in;
  logic [4:0] level;
  logic       overflow;
  logic       done;
  logic       ce_run;

  int n_checks;
  int n_errors;
  int pop_idx;
  logic [21:0] exp_addr [16];
  logic [7:0]  exp_data [16];
  logic        saw_done;

  loader_write_fifo_if bus ();

  loader_write_fifo #(
    .DEPTH_LOG2 (4),
    .SLOT       (2'd3)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .nes_ce       (nes_ce),
    .load_done_in (load_done_in),
    .level        (level),
    .overflow     (overflow),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ce_run) nes_ce = nes_ce + 2'd1;
  endtask

  // Advances one clock; on a slot edge compares the drained entry with the next expected one.
  task automatic tick_watch();
    logic [1:0] ce_pre;
    ce_pre = nes_ce;
    tick();
    if (ce_pre == 2'd3 && pop_idx < 16) begin
      check_val("drain_we",   {31'd0, bus.mem_write}, 32'd1);
      check_val("drain_addr", {10'd0, bus.mem_addr},  {10'd0, exp_addr[pop_idx]});
      check_val("drain_data", {24'd0, bus.mem_data},  {24'd0, exp_data[pop_idx]});
      pop_idx++;
    end
  endtask

  task automatic drain_all();
    for (int t = 0; t < 200 && pop_idx < 16; t++) tick_watch();
    check_val("drain_count", pop_idx, 16);
    repeat (4) tick();
    check_val("drain_end_we",  {31'd0, bus.mem_write}, 32'd0);
    check_val("drain_end_lvl", {27'd0, level}, 32'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; pop_idx = 0;
    reset = 1'b1; nes_ce = 2'd0; ce_run = 1'b0; load_done_in = 1'b0;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0;
    tick(); tick();
    reset = 1'b0;

    check_val("rst_level", {27'd0, level}, 32'd0);
    check_val("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check_val("rst_ovf",   {31'd0, overflow}, 32'd0);
    check_val("rst_we",    {31'd0, bus.mem_write}, 32'd0);
    check_val("rst_done",  {31'd0, done}, 32'd0);
    check_val("rst_addr",  {10'd0, bus.mem_addr}, 32'd0);
    check_val("rst_data",  {24'd0, bus.mem_data}, 32'd0);

    // Single byte pushed at a nes_ce=0 edge
    nes_ce = 2'd0; ce_run = 1'b1;
    bus.in_valid = 1'b1; bus.in_addr = 22'h000010; bus.in_data = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    check_val("single_lvl1", {27'd0, level}, 32'd1);
    tick(); tick();
    check_val("single_we_pre", {31'd0, bus.mem_write}, 32'd0);
    tick();
    check_val("single_we",   {31'd0, bus.mem_write}, 32'd1);
    check_val("single_addr", {10'd0, bus.mem_addr}, 32'h10);
    check_val("single_data", {24'd0, bus.mem_data}, 32'hA5);
    check_val("single_lvl0", {27'd0, level}, 32'd0);
    tick(); tick(); tick();
    check_val("single_hold", {31'd0, bus.mem_write}, 32'd1);
    tick();
    check_val("single_we_off", {31'd0, bus.mem_write}, 32'd0);
    check_val("single_lvl_end", {27'd0, level}, 32'd0);

    // Burst of 16 consecutive pushes while slots keep draining
    nes_ce = 2'd0; pop_idx = 0;
    for (int i = 0; i < 16; i++) begin
      exp_addr[i] = 22'h000100 + 22'(i);
      exp_data[i] = 8'h30 + 8'(i);
    end
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1; bus.in_addr = exp_addr[i]; bus.in_data = exp_data[i];
      check_val("burst_ready", {31'd0, bus.in_ready}, 32'd1);
      tick_watch();
    end
    bus.in_valid = 1'b0;
    check_val("burst_level", {27'd0, level}, 32'd12);
    drain_all();
    check_val("burst_ovf", {31'd0, overflow}, 32'd0);

    // Overflow: fill with no slot, then push one more
    ce_run = 1'b0; nes_ce = 2'd0; pop_idx = 0;
    for (int i = 0; i < 16; i++) begin
      exp_addr[i] = 22'h000200 + 22'(i);
      exp_data[i] = 8'h50 + 8'(i);
      bus.in_valid = 1'b1; bus.in_addr = exp_addr[i]; bus.in_data = exp_data[i];
      tick();
    end
    check_val("full_level", {27'd0, level}, 32'd16);
    check_val("full_ready", {31'd0, bus.in_ready}, 32'd0);
    check_val("full_ovf0",  {31'd0, overflow}, 32'd0);
    bus.in_addr = 22'h3FFFFF; bus.in_data = 8'hFF;
    tick();
    bus.in_valid = 1'b0;
    check_val("drop_ovf",   {31'd0, overflow}, 32'd1);
    check_val("drop_level", {27'd0, level}, 32'd16);
    nes_ce = 2'd3; ce_run = 1'b1;
    check_val("full_slot_ready", {31'd0, bus.in_ready}, 32'd0);
    tick_watch();
    check_val("after_pop_ready", {31'd0, bus.in_ready}, 32'd1);
    check_val("after_pop_level", {27'd0, level}, 32'd15);
    drain_all();
    check_val("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Simultaneous push and pop with level 1
    nes_ce = 2'd0;
    bus.in_valid = 1'b1; bus.in_addr = 22'h000055; bus.in_data = 8'h11;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    bus.in_valid = 1'b1; bus.in_addr = 22'h000066; bus.in_data = 8'h22;
    tick();
    bus.in_valid = 1'b0;
    check_val("simul_level", {27'd0, level}, 32'd1);
    check_val("simul_data1", {24'd0, bus.mem_data}, 32'h11);
    tick(); tick(); tick();
    check_val("simul_hold", {24'd0, bus.mem_data}, 32'h11);
    tick();
    check_val("simul_data2", {24'd0, bus.mem_data}, 32'h22);
    check_val("simul_addr2", {10'd0, bus.mem_addr}, 32'h66);
    check_val("simul_lvl0",  {27'd0, level}, 32'd0);

    // Done with 3 bytes queued
    load_done_in = 1'b1; saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_addr = 22'h000300 + 22'(i); bus.in_data = 8'hC0 + 8'(i);
      tick();
      saw_done |= done;
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      saw_done |= done;
    end
    check_val("done_early", {31'd0, saw_done}, 32'd0);
    check_val("done_last_we", {31'd0, bus.mem_write}, 32'd1);
    check_val("done_last_data", {24'd0, bus.mem_data}, 32'hC2);
    tick();
    check_val("done_we_fall", {31'd0, bus.mem_write}, 32'd0);
    check_val("done_still0", {31'd0, done}, 32'd0);
    tick();
    check_val("done_rise", {31'd0, done}, 32'd1);

    // A byte arriving while done is high is still accepted
    bus.in_valid = 1'b1; bus.in_addr = 22'h0003FF; bus.in_data = 8'h77;
    tick();
    bus.in_valid = 1'b0;
    check_val("late_done", {31'd0, done}, 32'd0);
    check_val("late_level", {27'd0, level}, 32'd1);
    repeat (7) tick();
    check_val("late_data", {24'd0, bus.mem_data}, 32'h77);
    check_val("late_done_again", {31'd0, done}, 32'd1);
    load_done_in = 1'b0;
    tick();
    check_val("done_fall", {31'd0, done}, 32'd0);

    // Reset mid-drain
    ce_run = 1'b0; nes_ce = 2'd0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.in_addr = 22'h000400 + 22'(i); bus.in_data = 8'h90 + 8'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    nes_ce = 2'd3;
    tick();
    nes_ce = 2'd1;
    check_val("pre_rst_level", {27'd0, level}, 32'd5);
    check_val("pre_rst_we",    {31'd0, bus.mem_write}, 32'd1);
    check_val("pre_rst_ovf",   {31'd0, overflow}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("mid_rst_level", {27'd0, level}, 32'd0);
    check_val("mid_rst_we",    {31'd0, bus.mem_write}, 32'd0);
    check_val("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check_val("mid_rst_ovf",   {31'd0, overflow}, 32'd0);
    check_val("mid_rst_done",  {31'd0, done}, 32'd0);
    nes_ce = 2'd3;
    tick();
    nes_ce = 2'd0;
    check_val("post_rst_we",    {31'd0, bus.mem_write}, 32'd0);
    check_val("post_rst_level", {27'd0, level}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/loader_write_fifo.md
LOADER_WRITE_FIFO -- requirements
Module: loader_write_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4: FIFO depth is 2**DEPTH_LOG2 entries.
REQ-002 Parameter SLOT, default 2'd3: nes_ce value at which an SDRAM write slot opens.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  loader byte present (game_loader mem_write strobe).
REQ-006 in_addr  input  22  loader target address.
REQ-007 in_data  input  8  loader byte.
REQ-008 in_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 nes_ce  input  2  NES clock-enable phase counter.
REQ-010 load_done_in  input  1  game_loader done flag.
REQ-011 mem_addr  output  22  SDRAM port-A address (registered).
REQ-012 mem_data  output  8  SDRAM port-A write data (registered).
REQ-013 mem_write  output  1  SDRAM port-A write enable (registered).
REQ-014 level  output  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
REQ-015 overflow  output  1  sticky: a byte was dropped.
REQ-016 done  output  1  load complete and every byte written to SDRAM.

Function
REQ-017 Storage: circular buffer of {addr,data}; read and write pointers DEPTH_LOG2 bits, wrapping modulo depth; level tracked explicitly so full and empty are distinguishable.
REQ-018 in_ready = (level != 2**DEPTH_LOG2), decoded from registered state only.
REQ-019 Push: when in_valid & in_ready, entry written at the write pointer; pointer and level advance at the same edge.
REQ-020 Drop: in_valid while not in_ready discards the byte, sets overflow, and leaves pointers and level unchanged.
REQ-021 Slot cycle: any cycle with nes_ce == SLOT.
REQ-022 On a slot cycle with level != 0: mem_addr/mem_data load the head entry, mem_write <= 1, read pointer advances, level decrements.
REQ-023 On a slot cycle with level == 0: mem_write <= 0; mem_addr and mem_data hold their values.
REQ-024 mem_write, mem_addr and mem_data change only on slot cycles, so each write is held for one full 4-cycle nes_ce period.
REQ-025 Pop eligibility uses level at the start of the cycle: a byte pushed on a slot cycle is not popped until the next slot cycle.
REQ-026 Simultaneous push and pop: both occur and level is unchanged.
REQ-027 When full on a slot cycle, in_ready stays 0 for that cycle even though a pop occurs; in_ready rises the next cycle.
REQ-028 Throughput: at most one drain per 4 clocks.
REQ-029 Latency: a byte pushed at edge t appears on mem_* at the first slot-cycle edge strictly after t.
REQ-030 done is registered: done <= load_done_in & (level == 0) & ~mem_write & ~in_valid.
REQ-031 done deasserts the cycle after load_done_in falls.
REQ-032 If in_valid arrives while load_done_in is 1, it is still accepted and done falls.

Reset
REQ-033 reset clears pointers, level, overflow, mem_write, done, mem_addr and mem_data to 0; in_ready is 1 after reset.
REQ-034 reset mid-operation discards all buffered entries and forces mem_write to 0 at that edge, regardless of nes_ce.
REQ-035 Overflow clears only on reset.

Verification
REQ-036 Single byte: push addr 22'h000010, data 8'hA5 with nes_ce=0 -> three cycles later (nes_ce=3 edge) mem_write=1, mem_addr=22'h000010, mem_data=8'hA5, held 4 cycles; then mem_write=0 and level=0.
REQ-037 Burst: push 16 bytes on consecutive cycles (DEPTH_LOG2=4) -> all accepted, level peaks at 16 minus pops, in_ready=0 while full, mem_* emits the 16 bytes in order, one per 4 clocks, with no overflow.
REQ-038 Overflow: fill 16 entries with no slot occurring (nes_ce held at 0), then push 8'hFF -> byte dropped, overflow=1, level stays 16; drain yields the original 16 bytes only.
REQ-039 Simultaneous: level=1 and a push on a slot cycle -> level stays 1 and the new byte drains exactly 4 clocks later.
REQ-040 Done: load_done_in=1 with 3 bytes queued -> done stays 0 until the third write's mem_write falls, then done=1 the following cycle.
REQ-041 Reset mid-drain: assert reset with level=5 and mem_write=1 -> next edge level=0, mem_write=0, in_ready=1, overflow=0, done=0.
